// File: rtl/einstein_kb_pkg.sv
// Shared types and constants for the Einstein PS/2 keyboard front end.
// The KB_RESET_KEY_EN build option lives in einstein_ps2_kbd.sv.
package einstein_kb_pkg;

    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 3;
    localparam int unsigned N_KEYS = 64;
    localparam int unsigned PAUSE_SKIP = 7;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CTRL   = 8'h14;
    localparam logic [7:0] PS2_ALT    = 8'h11;
    localparam logic [7:0] PS2_F12    = 8'h07;

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } key_pos_t;

    typedef enum logic [2:0] {
        DEC_BASE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK,
        DEC_SKIP
    } dec_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic key_pos_t kp(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        key_pos_t k;
        k.valid = 1'b1;
        k.row   = r;
        k.col   = c;
        return k;
    endfunction

    // Set-2 scan code (with E0 flag) to Einstein matrix position.
    function automatic key_pos_t keymap(input logic [7:0] code, input logic ext);
        key_pos_t k;
        k = '0;
        case ({ext, code})
            9'h016: k = kp(3'd0, 3'd0);
            9'h01E: k = kp(3'd0, 3'd1);
            9'h026: k = kp(3'd0, 3'd2);
            9'h025: k = kp(3'd0, 3'd3);
            9'h02E: k = kp(3'd0, 3'd4);
            9'h036: k = kp(3'd0, 3'd5);
            9'h03D: k = kp(3'd0, 3'd6);
            9'h03E: k = kp(3'd0, 3'd7);
            9'h01C: k = kp(3'd1, 3'd0);
            9'h01B: k = kp(3'd1, 3'd1);
            9'h023: k = kp(3'd1, 3'd2);
            9'h02B: k = kp(3'd1, 3'd3);
            9'h034: k = kp(3'd1, 3'd4);
            9'h033: k = kp(3'd1, 3'd5);
            9'h03B: k = kp(3'd1, 3'd6);
            9'h042: k = kp(3'd1, 3'd7);
            9'h015: k = kp(3'd2, 3'd0);
            9'h01D: k = kp(3'd2, 3'd1);
            9'h024: k = kp(3'd2, 3'd2);
            9'h02D: k = kp(3'd2, 3'd3);
            9'h02C: k = kp(3'd2, 3'd4);
            9'h035: k = kp(3'd2, 3'd5);
            9'h03C: k = kp(3'd2, 3'd6);
            9'h043: k = kp(3'd2, 3'd7);
            9'h01A: k = kp(3'd3, 3'd0);
            9'h022: k = kp(3'd3, 3'd1);
            9'h021: k = kp(3'd3, 3'd2);
            9'h02A: k = kp(3'd3, 3'd3);
            9'h032: k = kp(3'd3, 3'd4);
            9'h031: k = kp(3'd3, 3'd5);
            9'h03A: k = kp(3'd3, 3'd6);
            9'h041: k = kp(3'd3, 3'd7);
            9'h046: k = kp(3'd4, 3'd0);
            9'h045: k = kp(3'd4, 3'd1);
            9'h044: k = kp(3'd4, 3'd2);
            9'h04D: k = kp(3'd4, 3'd3);
            9'h04B: k = kp(3'd4, 3'd4);
            9'h04C: k = kp(3'd4, 3'd5);
            9'h049: k = kp(3'd4, 3'd6);
            9'h04A: k = kp(3'd4, 3'd7);
            9'h029: k = kp(3'd5, 3'd0);
            9'h05A: k = kp(3'd5, 3'd1);
            9'h066: k = kp(3'd5, 3'd2);
            9'h076: k = kp(3'd5, 3'd3);
            9'h00D: k = kp(3'd5, 3'd4);
            9'h04E: k = kp(3'd5, 3'd5);
            9'h055: k = kp(3'd5, 3'd6);
            9'h052: k = kp(3'd5, 3'd7);
            9'h005: k = kp(3'd6, 3'd0);
            9'h006: k = kp(3'd6, 3'd1);
            9'h004: k = kp(3'd6, 3'd2);
            9'h00C: k = kp(3'd6, 3'd3);
            9'h003: k = kp(3'd6, 3'd4);
            9'h00B: k = kp(3'd6, 3'd5);
            9'h083: k = kp(3'd6, 3'd6);
            9'h00A: k = kp(3'd6, 3'd7);
            9'h175: k = kp(3'd7, 3'd0);
            9'h172: k = kp(3'd7, 3'd1);
            9'h16B: k = kp(3'd7, 3'd2);
            9'h174: k = kp(3'd7, 3'd3);
            9'h007: k = kp(3'd7, 3'd4);
            9'h078: k = kp(3'd7, 3'd5);
            9'h170: k = kp(3'd7, 3'd6);
            9'h171: k = kp(3'd7, 3'd7);
            default: k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/einstein_ps2_kbd_if.sv
// Keyboard matrix link between the PSG ports and the keyboard front end.
interface einstein_ps2_kbd_if;
    logic [7:0] kb_row;
    logic [7:0] kb_col;
    logic       kb_shift;
    logic       kb_ctrl;
    logic       kb_graph;

    modport master (output kb_row, input kb_col, kb_shift, kb_ctrl, kb_graph);
    modport slave  (input kb_row, output kb_col, kb_shift, kb_ctrl, kb_graph);
endinterface

// File: rtl/einstein_ps2_rx.sv
// PS/2 frame receiver: input synchronisers, ps2_clk glitch filter, frame FSM and
// inter-edge timeout. Emits one-cycle byte_valid / rx_err pulses.
module einstein_ps2_rx
    import einstein_kb_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       rx_err,
    output logic       rx_timeout
);

    localparam int unsigned FLT_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TOUT_W = $clog2(TIMEOUT_CYC + 1);

    logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic             flt_q, flt_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             fall_c;

    rx_state_t        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;

    // Synchronisers and clock filter: a new ps2_clk level needs FILTER_LEN equal samples.
    always_comb begin
        clk_s1_d  = ps2_clk;
        clk_s2_d  = clk_s1_q;
        dat_s1_d  = ps2_data;
        dat_s2_d  = dat_s1_q;
        flt_d     = flt_q;
        flt_cnt_d = '0;
        if (clk_s2_q != flt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                flt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
        fall_c = flt_q & ~flt_d;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        tout_d    = (state_q == RX_IDLE || fall_c) ? '0 : tout_q + TOUT_W'(1);

        case (state_q)
            RX_IDLE: begin
                if (fall_c && !dat_s2_q) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = '0;
                end
            end
            RX_DATA: begin
                if (fall_c) begin
                    shreg_d   = {dat_s2_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (fall_c) begin
                    par_d   = dat_s2_q;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall_c) begin
                    if (dat_s2_q && (^{shreg_q, par_q})) begin
                        byte_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // A stalled frame is abandoned; the decoder is told so it can resync.
        if (state_q != RX_IDLE && tout_q >= TOUT_W'(TIMEOUT_CYC)) begin
            state_d   = RX_IDLE;
            valid_d   = 1'b0;
            err_d     = 1'b1;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            flt_q     <= 1'b1;
            flt_cnt_q <= '0;
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tout_q    <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            clk_s1_q  <= clk_s1_d;
            clk_s2_q  <= clk_s2_d;
            dat_s1_q  <= dat_s1_d;
            dat_s2_q  <= dat_s2_d;
            flt_q     <= flt_d;
            flt_cnt_q <= flt_cnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            tout_q    <= tout_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = valid_q;
    assign rx_err     = err_q;
    assign rx_timeout = timeout_q;

endmodule

// File: rtl/einstein_ps2_kbd.sv
// PS/2 keyboard front end: set-2 decoder, 64-key matrix, modifiers, kb_col scan.
// Define KB_RESET_KEY_EN to turn F12 into a key_reset pulse instead of a matrix key.
module einstein_ps2_kbd
    import einstein_kb_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned RESET_PULSE = 1024
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    einstein_ps2_kbd_if.slave kb,
    output logic              rx_err,
    output logic              key_reset
);

`ifdef KB_RESET_KEY_EN
    localparam bit RESET_KEY_EN = 1'b1;
`else
    localparam bit RESET_KEY_EN = 1'b0;
`endif

    localparam int unsigned RST_W = $clog2(RESET_PULSE + 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_timeout;

    einstein_ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .rx_err    (rx_err),
        .rx_timeout(rx_timeout)
    );

    dec_state_t        dec_q, dec_d;
    logic [2:0]        skip_q, skip_d;
    logic [N_KEYS-1:0] matrix_q, matrix_d;
    logic              shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic              ctrl_l_q, ctrl_l_d, ctrl_r_q, ctrl_r_d;
    logic              alt_l_q, alt_l_d, alt_r_q, alt_r_d;
    logic [7:0]        kb_col_q, kb_col_d;
    logic              kb_shift_q, kb_shift_d, kb_ctrl_q, kb_ctrl_d, kb_graph_q, kb_graph_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic              key_reset_q, key_reset_d;

    logic              do_key_c, key_make_c, key_ext_c, krst_trig_c;
    key_pos_t          key_pos_c;

    // Prefix decoder and key/modifier state update.
    always_comb begin
        dec_d       = dec_q;
        skip_d      = skip_q;
        matrix_d    = matrix_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        ctrl_l_d    = ctrl_l_q;
        ctrl_r_d    = ctrl_r_q;
        alt_l_d     = alt_l_q;
        alt_r_d     = alt_r_q;
        do_key_c    = 1'b0;
        key_make_c  = 1'b0;
        key_ext_c   = 1'b0;
        krst_trig_c = 1'b0;

        if (rx_timeout) begin
            dec_d  = DEC_BASE;
            skip_d = '0;
        end else if (rx_valid) begin
            case (dec_q)
                DEC_BASE: begin
                    if (rx_byte == PS2_EXT) begin
                        dec_d = DEC_EXT;
                    end else if (rx_byte == PS2_BRK) begin
                        dec_d = DEC_BRK;
                    end else if (rx_byte == PS2_PAUSE) begin
                        dec_d  = DEC_SKIP;
                        skip_d = 3'(PAUSE_SKIP);
                    end else if (rx_byte == PS2_BAT) begin
                        matrix_d = '0;
                    end else if (rx_byte == PS2_ACK || rx_byte == PS2_ECHO ||
                                 rx_byte == PS2_RESEND || rx_byte == PS2_ERR0 ||
                                 rx_byte == PS2_ERR1) begin
                        dec_d = DEC_BASE;
                    end else begin
                        do_key_c   = 1'b1;
                        key_make_c = 1'b1;
                    end
                end
                DEC_EXT: begin
                    if (rx_byte == PS2_BRK) begin
                        dec_d = DEC_EXT_BRK;
                    end else begin
                        do_key_c   = 1'b1;
                        key_make_c = 1'b1;
                        key_ext_c  = 1'b1;
                        dec_d      = DEC_BASE;
                    end
                end
                DEC_BRK: begin
                    do_key_c = 1'b1;
                    dec_d    = DEC_BASE;
                end
                DEC_EXT_BRK: begin
                    do_key_c  = 1'b1;
                    key_ext_c = 1'b1;
                    dec_d     = DEC_BASE;
                end
                DEC_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) dec_d = DEC_BASE;
                end
                default: dec_d = DEC_BASE;
            endcase
        end

        key_pos_c = keymap(rx_byte, key_ext_c);
        if (do_key_c) begin
            if (!key_ext_c && rx_byte == PS2_LSHIFT) begin
                shift_l_d = key_make_c;
            end else if (!key_ext_c && rx_byte == PS2_RSHIFT) begin
                shift_r_d = key_make_c;
            end else if (rx_byte == PS2_CTRL) begin
                if (key_ext_c) ctrl_r_d = key_make_c;
                else           ctrl_l_d = key_make_c;
            end else if (rx_byte == PS2_ALT) begin
                if (key_ext_c) alt_r_d = key_make_c;
                else           alt_l_d = key_make_c;
            end else if (RESET_KEY_EN && !key_ext_c && rx_byte == PS2_F12) begin
                krst_trig_c = key_make_c;
            end else if (key_pos_c.valid) begin
                matrix_d[{key_pos_c.row, key_pos_c.col}] = key_make_c;
            end
        end
    end

    // Column sense: OR of every pressed key across all selected rows.
    always_comb begin
        kb_col_d = '1;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (!kb.kb_row[r] && matrix_q[{3'(r), 3'(c)}]) kb_col_d[c] = 1'b0;
            end
        end
        kb_shift_d = shift_l_q | shift_r_q;
        kb_ctrl_d  = ctrl_l_q | ctrl_r_q;
        kb_graph_d = alt_l_q | alt_r_q;
    end

    // Retriggerable reset pulse; high for exactly RESET_PULSE cycles after the last trigger.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (krst_trig_c) begin
            rst_cnt_d = RST_W'(RESET_PULSE);
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
        key_reset_d = (rst_cnt_d != '0);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dec_q       <= DEC_BASE;
            skip_q      <= '0;
            matrix_q    <= '0;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            ctrl_l_q    <= 1'b0;
            ctrl_r_q    <= 1'b0;
            alt_l_q     <= 1'b0;
            alt_r_q     <= 1'b0;
            kb_col_q    <= 8'hFF;
            kb_shift_q  <= 1'b0;
            kb_ctrl_q   <= 1'b0;
            kb_graph_q  <= 1'b0;
            rst_cnt_q   <= '0;
            key_reset_q <= 1'b0;
        end else begin
            dec_q       <= dec_d;
            skip_q      <= skip_d;
            matrix_q    <= matrix_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            ctrl_l_q    <= ctrl_l_d;
            ctrl_r_q    <= ctrl_r_d;
            alt_l_q     <= alt_l_d;
            alt_r_q     <= alt_r_d;
            kb_col_q    <= kb_col_d;
            kb_shift_q  <= kb_shift_d;
            kb_ctrl_q   <= kb_ctrl_d;
            kb_graph_q  <= kb_graph_d;
            rst_cnt_q   <= rst_cnt_d;
            key_reset_q <= key_reset_d;
        end
    end

    assign kb.kb_col   = kb_col_q;
    assign kb.kb_shift = kb_shift_q;
    assign kb.kb_ctrl  = kb_ctrl_q;
    assign kb.kb_graph = kb_graph_q;
    assign key_reset   = key_reset_q;

endmodule
